uart_alu_ctrl: RTL

- Synchronous, parametrised controller between the UART receiver, the ALU and the UART transmitter.
- Collects operand A, operand B and the opcode as three consecutive RX bytes and drives them to the ALU.
- Samples the ALU result, splits it into RESULT_BYTES bytes and sends them through TX, one byte per TX handshake.
- Replaces the combinational, counter-in-always-block interface with a registered FSM. Adds TX-done handshaking, overrun detection and an optional inter-byte timeout.

---
 rtl/uart_alu_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects A, B and opcode from RX, freezes the ALU result and sends it over TX.
// Define UART_ALU_CTRL_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle cycles.
module uart_alu_ctrl #(
    parameter int NBIT_DATA_LEN  = 8,
    parameter int NBIT_OP_LEN    = 6,
    parameter int RESULT_BYTES   = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    rx_done_tick,
    input  logic [NBIT_DATA_LEN-1:0]                rx_data_in,
    input  logic [NBIT_DATA_LEN*RESULT_BYTES-1:0]   alu_result,
    input  logic                                    tx_done_tick,
    output logic [NBIT_DATA_LEN-1:0]                A,
    output logic [NBIT_DATA_LEN-1:0]                B,
    output logic [NBIT_OP_LEN-1:0]                  Op,
    output logic                                    tx_start,
    output logic [NBIT_DATA_LEN-1:0]                tx_data,
    output logic                                    busy,
    output logic                                    overrun,
    output logic                                    timeout
);
    localparam int RW = NBIT_DATA_LEN * RESULT_BYTES;
    localparam int IW = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;

    if (NBIT_OP_LEN > NBIT_DATA_LEN || RESULT_BYTES < 1 || RESULT_BYTES > 4 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("uart_alu_ctrl: invalid parameter combination");
    end

    typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX} state_t;

    state_t                     state_q, state_d;
    logic [NBIT_DATA_LEN-1:0]   a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
    logic [NBIT_OP_LEN-1:0]     op_q, op_d;
    logic [RW-1:0]              res_q, res_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic                       tx_start_q, tx_start_d, busy_q, busy_d, overrun_q, overrun_d;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       timeout_q, timeout_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        case (state_q)
            WAIT_A:  if (rx_done_tick) begin
                a_d       = rx_data_in;
                overrun_d = 1'b0;
                state_d   = WAIT_B;
            end
            WAIT_B:  if (rx_done_tick) begin
                b_d     = rx_data_in;
                state_d = WAIT_OP;
            end
            WAIT_OP: if (rx_done_tick) begin
                op_d    = rx_data_in[NBIT_OP_LEN-1:0];
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = alu_result;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND:    state_d = WAIT_TX;
            WAIT_TX: if (tx_done_tick) begin
                state_d = (idx_q == IW'(RESULT_BYTES - 1)) ? WAIT_A : SEND;
                idx_d   = (idx_q == IW'(RESULT_BYTES - 1)) ? idx_q : idx_q + 1'b1;
            end
            default: state_d = WAIT_A;
        endcase
        // Bytes arriving while the result is being handled are dropped, not queued.
        if (rx_done_tick && (state_q inside {EXEC, SEND, WAIT_TX}))
            overrun_d = 1'b1;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
        cnt_d     = '0;
        timeout_d = 1'b0;
        if ((state_q == WAIT_B || state_q == WAIT_OP) && !rx_done_tick) begin
            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d   = WAIT_A;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
        tx_start_d = (state_d == SEND);
        busy_d     = (state_d inside {EXEC, SEND, WAIT_TX});
        tx_data_d  = (state_d == SEND) ? res_d[int'(idx_d)*NBIT_DATA_LEN +: NBIT_DATA_LEN] : tx_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_q      <= res_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign Op       = op_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif
endmodule
